nf10_param_output_queues: RTL and testbench

- Parametrised successor to the fixed five-port BRAM output queues.
- Demultiplexes one 256-bit AXI4-Stream input into C_NUM_QUEUES independent store-and-forward packet queues, selected by a one-hot destination field in tuser (multicast allowed).
- Per-packet, per-queue admission control: a copy is dropped cleanly rather than truncated. Per-queue stored/dropped packet counters are exported for the register block.
- Sits between output port lookup and the MAC/DMA egress interfaces.

---
 rtl/nf10_param_output_queues_pkg.sv | 31 +++
 rtl/nf10_oq_pkt_fifo.sv | 64 ++++++
 rtl/nf10_param_output_queues.sv | 141 ++++++++++++++
 tb/tb_nf10_param_output_queues.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_param_output_queues_pkg.sv
`default_nettype none
// ============================================================================
// nf10_param_output_queues_pkg : shared types and helpers for the output queues
// Revision 1.0
// ============================================================================
package nf10_param_output_queues_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    localparam int CNT_WIDTH  = 32;
    localparam int MAX_QUEUES = 8;
    localparam int TUSER_MAX  = 1024;

    function automatic int entry_width(input int data_w, input int tuser_w);
        return data_w + data_w / 8 + tuser_w + 1;
    endfunction

    // Bits above the configured queue count are forced to zero so they can
    // never count as a destination.
    function automatic logic [MAX_QUEUES-1:0] dst_field(input logic [TUSER_MAX-1:0] tuser,
                                                        input int pos, input int nq);
        logic [MAX_QUEUES-1:0] keep;
        keep = '0;
        for (int i = 0; i < MAX_QUEUES; i++) keep[i] = (i < nq);
        return tuser[pos +: MAX_QUEUES] & keep;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf10_oq_pkt_fifo.sv
`default_nettype none
// ============================================================================
// nf10_oq_pkt_fifo : one show-ahead packet queue (BRAM + output register)
// Revision 1.0
// ============================================================================
module nf10_oq_pkt_fifo
    import nf10_param_output_queues_pkg::*;
#(
    parameter int WIDTH      = 417,
    parameter int DEPTH_BITS = 9
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_BITS:0]   free_words
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_BITS:0]   CNT_ONE = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   bram_cnt;
    logic                  pop;
    logic                  load;

    assign pop  = out_valid & out_ready;
    // Refill the output register whenever it is empty or being drained.
    assign load = (bram_cnt != '0) & (~out_valid | pop);
    assign free_words = CW'(DEPTH) - bram_cnt - {{DEPTH_BITS{1'b0}}, out_valid};

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
        if (load)  out_data    <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            bram_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (load)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, load})
                2'b10:   bram_cnt <= bram_cnt + CNT_ONE;
                2'b01:   bram_cnt <= bram_cnt - CNT_ONE;
                default: bram_cnt <= bram_cnt;
            endcase
            if (load)     out_valid <= 1'b1;
            else if (pop) out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nf10_param_output_queues.sv
`default_nettype none
// ============================================================================
// nf10_param_output_queues : AXI4-Stream demux into N store-and-forward queues
// Revision 1.0
// ============================================================================
module nf10_param_output_queues
    import nf10_param_output_queues_pkg::*;
#(
    parameter int C_NUM_QUEUES       = 5,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_DST_POS          = 24,
    parameter int C_DEPTH_BITS       = 9,
    parameter int C_MAX_PKT_WORDS    = 64
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]                  s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]                s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                 s_axis_tuser,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    input  logic                                          s_axis_tlast,
    output logic [C_NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic [C_NUM_QUEUES-1:0]                       m_axis_tvalid,
    input  logic [C_NUM_QUEUES-1:0]                       m_axis_tready,
    output logic [C_NUM_QUEUES-1:0]                       m_axis_tlast,
    input  logic                                          cnt_clear,
    output logic [C_NUM_QUEUES*32-1:0]                    pkt_stored_cnt,
    output logic [C_NUM_QUEUES*32-1:0]                    pkt_dropped_cnt,
    output logic [31:0]                                   pkt_nodst_cnt
);

    localparam int NQ = C_NUM_QUEUES;
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int EW = entry_width(DW, UW);
    localparam int FW = C_DEPTH_BITS + 1;
    localparam logic [C_DEPTH_BITS:0] ADMIT_WORDS = FW'(C_MAX_PKT_WORDS);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = 1;

    logic [1:0]              state;
    logic                    in_ready;
    logic [NQ-1:0]           wr_mask_q;
    logic [MAX_QUEUES-1:0]   dst_all;
    logic [NQ-1:0]           dst;
    logic [NQ-1:0]           admit;
    logic [NQ-1:0]           accept;
    logic [NQ-1:0]           wr_mask;
    logic                    beat;
    logic                    sop;
    logic [EW-1:0]           wr_entry;
    logic [EW-1:0]           q_out  [NQ];
    logic [C_DEPTH_BITS:0]   q_free [NQ];
    logic [CNT_WIDTH-1:0]    nodst;

    assign s_axis_tready = in_ready;
    assign beat     = s_axis_tvalid & in_ready;
    assign sop      = beat & (state == ST_IDLE);
    assign dst_all  = dst_field(TUSER_MAX'(s_axis_tuser), C_DST_POS, NQ);
    assign dst      = dst_all[NQ-1:0];
    assign accept   = dst & admit;
    assign wr_entry = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
    assign pkt_nodst_cnt = nodst;

    // The SOP beat uses the live admission result; later beats use the latch.
    always_comb begin
        wr_mask = '0;
        if (sop)                              wr_mask = accept;
        else if (beat && state == ST_WRITE)   wr_mask = wr_mask_q;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state     <= ST_IDLE;
            wr_mask_q <= '0;
            in_ready  <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (beat && !s_axis_tlast) begin
                        wr_mask_q <= accept;
                        state     <= (accept != '0) ? ST_WRITE : ST_DROP;
                    end
                end
                ST_WRITE, ST_DROP: begin
                    if (beat && s_axis_tlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn || cnt_clear)      nodst <= '0;
        else if (sop && dst_all == '0)     nodst <= nodst + CNT_ONE;
    end

    for (genvar q = 0; q < NQ; q++) begin : g_queue
        logic [CNT_WIDTH-1:0] stored;
        logic [CNT_WIDTH-1:0] dropped;

        assign admit[q] = (q_free[q] >= ADMIT_WORDS);

        nf10_oq_pkt_fifo #(
            .WIDTH      (EW),
            .DEPTH_BITS (C_DEPTH_BITS)
        ) u_fifo (
            .clk        (axi_aclk),
            .resetn     (axi_resetn),
            .wr_en      (wr_mask[q]),
            .wr_data    (wr_entry),
            .out_data   (q_out[q]),
            .out_valid  (m_axis_tvalid[q]),
            .out_ready  (m_axis_tready[q]),
            .free_words (q_free[q])
        );

        assign {m_axis_tdata[q*DW +: DW], m_axis_tstrb[q*SW +: SW],
                m_axis_tuser[q*UW +: UW], m_axis_tlast[q]} = q_out[q];

        always_ff @(posedge axi_aclk) begin
            if (!axi_resetn || cnt_clear) begin
                stored  <= '0;
                dropped <= '0;
            end else if (sop && dst[q]) begin
                if (admit[q]) stored  <= stored + CNT_ONE;
                else          dropped <= dropped + CNT_ONE;
            end
        end

        assign pkt_stored_cnt[q*CNT_WIDTH +: CNT_WIDTH]  = stored;
        assign pkt_dropped_cnt[q*CNT_WIDTH +: CNT_WIDTH] = dropped;
    end

endmodule
`default_nettype wire

// File: tb/tb_nf10_param_output_queues.sv
`default_nettype none
// ============================================================================
// tb_nf10_param_output_queues : directed self-checking bench (queue depth 128)
// Revision 1.0
// ============================================================================
module tb_nf10_param_output_queues;

    localparam int NQ = 5;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    logic                 axi_aclk = 1'b0;
    logic                 axi_resetn;
    logic [DW-1:0]        s_axis_tdata;
    logic [SW-1:0]        s_axis_tstrb;
    logic [UW-1:0]        s_axis_tuser;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic [NQ*DW-1:0]     m_axis_tdata;
    logic [NQ*SW-1:0]     m_axis_tstrb;
    logic [NQ*UW-1:0]     m_axis_tuser;
    logic [NQ-1:0]        m_axis_tvalid;
    logic [NQ-1:0]        m_axis_tready;
    logic [NQ-1:0]        m_axis_tlast;
    logic                 cnt_clear;
    logic [NQ*32-1:0]     pkt_stored_cnt;
    logic [NQ*32-1:0]     pkt_dropped_cnt;
    logic [31:0]          pkt_nodst_cnt;

    nf10_param_output_queues #(
        .C_NUM_QUEUES(NQ), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW),
        .C_DST_POS(24), .C_DEPTH_BITS(7), .C_MAX_PKT_WORDS(64)
    ) dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .cnt_clear(cnt_clear), .pkt_stored_cnt(pkt_stored_cnt),
        .pkt_dropped_cnt(pkt_dropped_cnt), .pkt_nodst_cnt(pkt_nodst_cnt)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        int              q;
        logic [DW-1:0]   d;
        logic [SW-1:0]   s;
        logic [UW-1:0]   u;
        logic            l;
    } beat_t;

    typedef struct {
        logic [4:0] dst;
        int         len;
        logic [4:0] exp_mask;
    } vec_t;

    beat_t cap[$];
    int    total = 0;
    int    bad = 0;
    int    ready_low = 0;

    always @(negedge axi_aclk) begin
        for (int q = 0; q < NQ; q++) begin
            if (axi_resetn && m_axis_tvalid[q] && m_axis_tready[q])
                cap.push_back('{q, m_axis_tdata[q*DW +: DW], m_axis_tstrb[q*SW +: SW],
                                m_axis_tuser[q*UW +: UW], m_axis_tlast[q]});
        end
    end

    function automatic logic [DW-1:0] mk_data(input logic [7:0] id, input int i);
        logic [7:0] ix;
        ix = i[7:0];
        return {16{id, ix}};
    endfunction

    function automatic logic [SW-1:0] mk_strb(input logic [7:0] id, input int i);
        logic [7:0] ix;
        ix = i[7:0];
        return {id[3:0], ix[3:0], 24'hFFFFFF};
    endfunction

    function automatic logic [UW-1:0] mk_user(input logic [4:0] dst, input logic [7:0] id, input int i);
        logic [UW-1:0] u;
        u = '0;
        u[7:0]     = i[7:0];
        u[15:8]    = id;
        u[28:24]   = dst;
        u[127:120] = ~id;
        return u;
    endfunction

    function automatic logic [31:0] stored(input int q);
        return pkt_stored_cnt[q*32 +: 32];
    endfunction

    function automatic logic [31:0] dropped(input int q);
        return pkt_dropped_cnt[q*32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Words captured for queue q must be npk packets of plen words, ids id0, id0+1, ...
    task automatic check_q(input string nm, input int q, input logic [4:0] dst,
                           input logic [7:0] id0, input int plen, input int npk);
        int k;
        int nbad;
        int ix;
        logic [7:0] id;
        k = 0;
        nbad = 0;
        foreach (cap[j]) begin
            if (cap[j].q == q) begin
                if (plen > 0) begin
                    id = id0 + 8'(k / plen);
                    ix = k % plen;
                    if (cap[j].d !== mk_data(id, ix) || cap[j].s !== mk_strb(id, ix) ||
                        cap[j].u !== mk_user(dst, id, ix) || cap[j].l !== (ix == plen - 1))
                        nbad++;
                end
                k++;
            end
        end
        total++;
        if (k != plen * npk) begin
            bad++;
            $display("FAIL %s q%0d word count: got %0d want %0d", nm, q, k, plen * npk);
        end
        if (plen * npk > 0) begin
            total++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL %s q%0d content: got %0d bad words want 0", nm, q, nbad);
            end
        end
    endtask

    task automatic step;
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic drive(input logic [4:0] dst, input logic [7:0] id, input int i, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = mk_data(id, i);
        s_axis_tstrb  = mk_strb(id, i);
        s_axis_tuser  = mk_user(dst, id, i);
        s_axis_tlast  = last;
    endtask

    task automatic idle_in;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [4:0] dst, input logic [7:0] id, input int len);
        for (int i = 0; i < len; i++) begin
            drive(dst, id, i, i == len - 1);
            if (!s_axis_tready) ready_low++;
            step();
        end
        idle_in();
    endtask

    initial begin
        vec_t vecs [5];
        int   exp_st [NQ];
        int   exp_nodst;
        logic [7:0] id;

        vecs[0] = '{5'b10011, 1, 5'b10011};
        vecs[1] = '{5'b01000, 5, 5'b01000};
        vecs[2] = '{5'b11111, 2, 5'b11111};
        vecs[3] = '{5'b00010, 4, 5'b00010};
        vecs[4] = '{5'b00000, 4, 5'b00000};
        exp_st    = '{0, 0, 1, 0, 0};
        exp_nodst = 0;

        axi_resetn    = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = '1;
        cnt_clear     = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst tready", 256'(s_axis_tready), 256'(0));
        chk("rst stored", 256'(pkt_stored_cnt), 256'(0));
        chk("rst dropped", 256'(pkt_dropped_cnt), 256'(0));
        chk("rst nodst", 256'(pkt_nodst_cnt), 256'(0));
        axi_resetn = 1'b1;
        step();
        chk("post-rst tready", 256'(s_axis_tready), 256'(1));

        // Unicast with first-word latency
        cap.delete();
        drive(5'b00100, 8'h01, 0, 1'b0);
        step();
        chk("uni tvalid@sop+1", 256'(m_axis_tvalid), 256'(0));
        chk("uni stored2", 256'(stored(2)), 256'(1));
        drive(5'b00100, 8'h01, 1, 1'b0);
        step();
        chk("uni tvalid@sop+2", 256'(m_axis_tvalid), 256'(5'b00100));
        chk("uni first data", m_axis_tdata[2*DW +: DW], mk_data(8'h01, 0));
        drive(5'b00100, 8'h01, 2, 1'b1);
        step();
        idle_in();
        repeat (6) step();
        for (int q = 0; q < NQ; q++) check_q("uni", q, 5'b00100, 8'h01, (q == 2) ? 3 : 0, 1);

        // Table of packets, all egress ports ready
        for (int r = 0; r < 5; r++) begin
            cap.delete();
            ready_low = 0;
            id = 8'h10 + 8'(r);
            send_pkt(vecs[r].dst, id, vecs[r].len);
            repeat (8) step();
            for (int q = 0; q < NQ; q++) begin
                check_q($sformatf("row%0d", r), q, vecs[r].dst, id,
                        vecs[r].exp_mask[q] ? vecs[r].len : 0, 1);
                if (vecs[r].exp_mask[q]) exp_st[q]++;
                chk($sformatf("row%0d stored q%0d", r, q), 256'(stored(q)), 256'(exp_st[q]));
            end
            if (vecs[r].dst == 5'b0) exp_nodst++;
            chk($sformatf("row%0d nodst", r), 256'(pkt_nodst_cnt), 256'(exp_nodst));
            chk($sformatf("row%0d tready low beats", r), 256'(ready_low), 256'(0));
        end

        // Counter clear on the same edge as an SOP
        cap.delete();
        drive(5'b00010, 8'h30, 0, 1'b1);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        idle_in();
        chk("clr stored1", 256'(stored(1)), 256'(0));
        chk("clr nodst", 256'(pkt_nodst_cnt), 256'(0));
        send_pkt(5'b00010, 8'h31, 1);
        chk("clr then stored1", 256'(stored(1)), 256'(1));
        repeat (6) step();
        check_q("clr", 1, 5'b00010, 8'h30, 1, 2);

        // Admission: queue 0 stalled, three 64-word packets back to back
        cap.delete();
        m_axis_tready = 5'b11110;
        for (int p = 0; p < 3; p++) send_pkt(5'b00001, 8'h40 + 8'(p), 64);
        chk("adm stored0", 256'(stored(0)), 256'(2));
        chk("adm dropped0", 256'(dropped(0)), 256'(1));
        for (int q = 1; q < NQ; q++) chk($sformatf("adm dropped%0d", q), 256'(dropped(q)), 256'(0));
        chk("adm stall tvalid0", 256'(m_axis_tvalid[0]), 256'(1));
        chk("adm stall data", m_axis_tdata[DW-1:0], mk_data(8'h40, 0));
        repeat (4) step();
        chk("adm stall data held", m_axis_tdata[DW-1:0], mk_data(8'h40, 0));
        m_axis_tready = '1;
        repeat (140) step();
        check_q("adm", 0, 5'b00001, 8'h40, 64, 2);

        // Reset during word 2 of a 5-word packet to queue 3
        cap.delete();
        drive(5'b01000, 8'h50, 0, 1'b0);
        step();
        drive(5'b01000, 8'h50, 1, 1'b0);
        axi_resetn = 1'b0;
        step();
        chk("midrst tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("midrst tready", 256'(s_axis_tready), 256'(0));
        chk("midrst stored", 256'(pkt_stored_cnt), 256'(0));
        chk("midrst dropped", 256'(pkt_dropped_cnt), 256'(0));
        axi_resetn = 1'b1;
        idle_in();
        step();
        chk("midrst tready back", 256'(s_axis_tready), 256'(1));
        send_pkt(5'b00001, 8'h60, 2);
        repeat (8) step();
        check_q("midrst", 0, 5'b00001, 8'h60, 2, 1);
        check_q("midrst", 3, 5'b01000, 8'h50, 0, 1);
        chk("midrst stored0", 256'(stored(0)), 256'(1));
        chk("midrst stored3", 256'(stored(3)), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
